add_bcd_conv: RTL

Downstream stage of the 8-bit adder `myadd`. Takes each `{cout, sum}` result as a 9-bit unsigned value and converts it to three BCD digits with a sequential double-dabble engine. Results go to the board display logic. Operands arrive and results leave on valid/ready handshakes, so the adder path can be stalled by a slow display consumer.

---
 rtl/add_bcd_pkg.sv | 27 ++
 rtl/add_bcd_conv_bcd7seg.sv | 28 ++
 rtl/add_bcd_conv.sv | 116 +++++++++++
 3 files changed

// File: rtl/add_bcd_pkg.sv
// Shared types and constants for the adder BCD conversion stage.
// Holds the conversion FSM states, digit/segment widths and the
// active-high gfedcba 7-segment patterns used by bcd7seg.
package add_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/add_bcd_conv_bcd7seg.sv
// Combinational decode of one BCD digit into an active-high gfedcba
// 7-segment pattern. Non-decimal codes blank the digit.
module bcd7seg
  import add_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [SEG_W-1:0]   seg_o
);

  // Look up the segment pattern for the incoming digit
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/add_bcd_conv.sv
// Sequential double-dabble converter for the {cout,sum} result of the
// 8-bit adder. One shift per cycle; valid/ready on both sides so a slow
// display consumer stalls the adder path.
// Optional macro ADD_BCD_SEG_EN adds a registered 7-segment output 'seg'.
module add_bcd_conv
  import add_bcd_pkg::*;
#(
  parameter int DW = 8,
  parameter int ND = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         sum,
  input  logic                  cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGIT_W*ND-1:0] bcd
`ifdef ADD_BCD_SEG_EN
  ,
  output logic [SEG_W*ND-1:0]   seg
`endif
);

  localparam int BW = DW + 1;
  localparam int SW = DIGIT_W * ND;
  localparam int CW = $clog2(BW + 1);

  state_e          state_q;
  logic [BW-1:0]   bin_q, bin_d;
  logic [SW-1:0]   scr_q, scr_adj, scr_d;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   bcd_q;
  logic            out_valid_q;

`ifdef ADD_BCD_SEG_EN
  logic [SEG_W*ND-1:0] seg_d, seg_q;

  // Decode the digits that will be captured into bcd on the last shift
  for (genvar g = 0; g < ND; g++) begin : g_seg
    bcd7seg u_dec (
      .digit_i (scr_d[g*DIGIT_W +: DIGIT_W]),
      .seg_o   (seg_d[g*SEG_W +: SEG_W])
    );
  end

  assign seg = seg_q;
`endif

  // One double-dabble step: add 3 to digits >= 5, then shift {scratch,binary}
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < ND; i++) begin
      if (scr_q[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        scr_adj[i*DIGIT_W +: DIGIT_W] = scr_q[i*DIGIT_W +: DIGIT_W] + 4'd3;
      end
    end
    scr_d = {scr_adj[SW-2:0], bin_q[BW-1]};
    bin_d = {bin_q[BW-2:0], 1'b0};
  end

  // Conversion FSM with registered result and valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      scr_q       <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef ADD_BCD_SEG_EN
      seg_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q   <= {cout, sum};
            scr_q   <= '0;
            cnt_q   <= CW'(BW);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q <= scr_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q       <= scr_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef ADD_BCD_SEG_EN
            seg_q       <= seg_d;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;

endmodule
